// File: rtl/spin_rdbuf_pkg.sv
// spin_rdbuf_pkg: shared state type and sizing helpers for the spin readout buffer.
package spin_rdbuf_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    function automatic int beats_f(input int n_spin, input int out_w);
        return (n_spin + out_w - 1) / out_w;
    endfunction

    function automatic int ptr_w_f(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w_f(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/spin_rdbuf_mem.sv
// spin_rdbuf_mem: DEPTH x N_SPIN register array with one write port and one combinational read port.
module spin_rdbuf_mem
    import spin_rdbuf_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int N_SPIN = 50,
    localparam int PTR_W = ptr_w_f(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [PTR_W-1:0]  i_waddr,
    input  logic [N_SPIN-1:0] i_wdata,
    input  logic [PTR_W-1:0]  i_raddr,
    output logic [N_SPIN-1:0] o_rdata
);

    logic [N_SPIN-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) mem_q[i_waddr] <= i_wdata;
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/spin_readout_buffer.sv
// spin_readout_buffer: stores one spin vector per run, then drains them to GPIO as OUT_W-bit beats.
// Define SPIN_RDBUF_HEADER_EN to prepend an entry-count header beat to the drain.
module spin_readout_buffer
    import spin_rdbuf_pkg::*;
#(
    parameter int N_SPIN = 50,
    parameter int DEPTH  = 16,
    parameter int OUT_W  = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clear,
    input  logic                       i_capture,
    input  logic [N_SPIN-1:0]          i_spin,
    input  logic                       i_final_run,
    output logic [OUT_W-1:0]           o_gpio_data,
    output logic                       o_gpio_valid,
    input  logic                       i_gpio_ready,
    output logic                       o_gpio_last,
    output logic [$clog2(DEPTH+1)-1:0] o_entry_count,
    output logic                       o_overflow,
    output logic                       o_drain_done
);

    localparam int BEATS  = beats_f(N_SPIN, OUT_W);
    localparam int BEAT_W = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int PTR_W  = ptr_w_f(DEPTH);
    localparam int CNT_W  = cnt_w_f(DEPTH);
    localparam int PAD_W  = BEATS * OUT_W;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, nxt_rd, raddr;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [BEAT_W-1:0]  beat_q, beat_d, nxt_beat;
    logic [OUT_W-1:0]   data_q, data_d;
    logic [N_SPIN-1:0]  rdata;
    logic               ovf_q, ovf_d, hdr_q, hdr_d, valid_q, valid_d, last_q, last_d;
    logic               we, arm;

    function automatic logic [OUT_W-1:0] beat_of(input logic [N_SPIN-1:0] s, input logic [BEAT_W-1:0] b);
        logic [PAD_W-1:0] p;
        p = PAD_W'(s);
        return p[b*OUT_W +: OUT_W];
    endfunction

    function automatic logic is_last(input logic [PTR_W-1:0] rd, input logic [BEAT_W-1:0] b,
                                     input logic [CNT_W-1:0] cnt);
        return b == BEAT_W'(BEATS - 1) && CNT_W'(rd) + CNT_W'(1) == cnt;
    endfunction

    spin_rdbuf_mem #(.DEPTH(DEPTH), .N_SPIN(N_SPIN)) u_mem (
        .i_clk   (i_clk),
        .i_we    (we),
        .i_waddr (wr_ptr_q),
        .i_wdata (i_spin),
        .i_raddr (raddr),
        .o_rdata (rdata)
    );

    // Position of the beat that follows the one currently presented; the header is followed by entry 0 beat 0.
    assign nxt_rd   = hdr_q ? '0 : (beat_q == BEAT_W'(BEATS - 1) ? rd_ptr_q + PTR_W'(1) : rd_ptr_q);
    assign nxt_beat = (hdr_q || beat_q == BEAT_W'(BEATS - 1)) ? '0 : beat_q + BEAT_W'(1);
    assign raddr    = state_q == ST_DRAIN ? nxt_rd : '0;
    assign arm      = state_q == ST_COLLECT && i_capture && i_final_run;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        beat_d   = beat_q;
        ovf_d    = ovf_q;
        hdr_d    = hdr_q;
        valid_d  = valid_q;
        last_d   = last_q;
        data_d   = data_q;
        we       = 1'b0;
        if (i_clear) begin
            state_d  = ST_COLLECT;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            beat_d   = '0;
            ovf_d    = 1'b0;
            hdr_d    = 1'b0;
            valid_d  = 1'b0;
            last_d   = 1'b0;
            data_d   = '0;
        end else begin
            if (i_capture) begin
                we       = state_q == ST_COLLECT && count_q < CNT_W'(DEPTH);
                wr_ptr_d = we ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
                count_d  = we ? count_q + CNT_W'(1) : count_q;
                ovf_d    = ovf_q | !we;
            end
            if (arm) begin
                rd_ptr_d = '0;
                beat_d   = '0;
`ifdef SPIN_RDBUF_HEADER_EN
                hdr_d    = 1'b1;
                data_d   = OUT_W'(count_d);
                if (OUT_W > CNT_W) data_d[OUT_W-1] = ovf_d;
                valid_d  = 1'b1;
                last_d   = count_d == '0;
`else
                // An empty buffer means entry 0 is being written at this very edge, so bypass the array.
                data_d   = beat_of(count_q == '0 ? i_spin : rdata, BEAT_W'(0));
                valid_d  = count_d != '0;
                last_d   = is_last(PTR_W'(0), BEAT_W'(0), count_d);
`endif
                state_d  = valid_d ? ST_DRAIN : ST_DONE;
            end else if (state_q == ST_DRAIN && valid_q && i_gpio_ready) begin
                hdr_d    = 1'b0;
                rd_ptr_d = nxt_rd;
                beat_d   = nxt_beat;
                data_d   = last_q ? '0 : beat_of(rdata, nxt_beat);
                valid_d  = !last_q;
                last_d   = !last_q && is_last(nxt_rd, nxt_beat, count_q);
                state_d  = last_q ? ST_DONE : ST_DRAIN;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_COLLECT;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
            ovf_q    <= 1'b0;
            hdr_q    <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            beat_q   <= beat_d;
            ovf_q    <= ovf_d;
            hdr_q    <= hdr_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            data_q   <= data_d;
        end
    end

    assign o_gpio_data   = data_q;
    assign o_gpio_valid  = valid_q;
    assign o_gpio_last   = last_q;
    assign o_entry_count = count_q;
    assign o_overflow    = ovf_q;
    assign o_drain_done  = state_q == ST_DONE;

endmodule

// File: tb/tb_spin_readout_buffer.sv
// tb_spin_readout_buffer: randomized scoreboard bench for spin_readout_buffer (N_SPIN=50, DEPTH=16, OUT_W=8).
module tb_spin_readout_buffer;

    localparam int BEATS = 7;
`ifdef SPIN_RDBUF_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_clear = 1'b0;
    logic        i_capture = 1'b0;
    logic [49:0] i_spin = '0;
    logic        i_final_run = 1'b0;
    logic        i_gpio_ready = 1'b1;
    logic [7:0]  o_gpio_data;
    logic        o_gpio_valid, o_gpio_last, o_overflow, o_drain_done;
    logic [4:0]  o_entry_count;

    int n_chk = 0;
    int n_fail = 0;
    int rdy_mode = 0;

    logic [8:0]  exp_q [$];
    logic [49:0] m_store [$];
    bit          m_collect = 1'b1;
    bit          m_ovf = 1'b0;

    spin_readout_buffer dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_clear       (i_clear),
        .i_capture     (i_capture),
        .i_spin        (i_spin),
        .i_final_run   (i_final_run),
        .o_gpio_data   (o_gpio_data),
        .o_gpio_valid  (o_gpio_valid),
        .i_gpio_ready  (i_gpio_ready),
        .o_gpio_last   (o_gpio_last),
        .o_entry_count (o_entry_count),
        .o_overflow    (o_overflow),
        .o_drain_done  (o_drain_done)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        if (rdy_mode == 1) i_gpio_ready = ~i_gpio_ready;
        else if (rdy_mode == 2) i_gpio_ready = 1'($urandom_range(0, 1));
        else i_gpio_ready = 1'b1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Every presented beat must equal the head of the scoreboard, including while stalled.
    always @(negedge clk) begin
        if (!i_rst && o_gpio_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_beat: got data=%0h last=%0b, required no beat", o_gpio_data, o_gpio_last);
            end else begin
                chk("beat_data", 64'(o_gpio_data), 64'(exp_q[0][7:0]));
                chk("beat_last", 64'(o_gpio_last), 64'(exp_q[0][8]));
                if (i_gpio_ready) void'(exp_q.pop_front());
            end
        end
    end

    function automatic logic [49:0] rnd();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[49:0];
    endfunction

    task automatic push_expected();
`ifdef SPIN_RDBUF_HEADER_EN
        logic [7:0] hv;
        hv = 8'(m_store.size()) | (m_ovf ? 8'h80 : 8'h00);
        exp_q.push_back({m_store.size() == 0, hv});
`endif
        foreach (m_store[e])
            for (int b = 0; b < BEATS; b++)
                exp_q.push_back({e == m_store.size() - 1 && b == BEATS - 1, 8'(m_store[e] >> (b * 8))});
    endtask

    task automatic model_reset();
        m_store.delete();
        exp_q.delete();
        m_collect = 1'b1;
        m_ovf = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cap(input logic [49:0] v, input bit fin);
        if (m_collect) begin
            if (m_store.size() < 16) m_store.push_back(v);
            else m_ovf = 1'b1;
            if (fin) begin
                m_collect = 1'b0;
                push_expected();
            end
        end else m_ovf = 1'b1;
        i_capture = 1'b1;
        i_spin = v;
        i_final_run = fin;
        @(posedge clk);
        #1;
        i_capture = 1'b0;
        i_final_run = 1'b0;
    endtask

    task automatic clear();
        i_clear = 1'b1;
        @(posedge clk);
        #1;
        i_clear = 1'b0;
        model_reset();
    endtask

    task automatic run_entries(input int n);
        for (int i = 0; i < n; i++) begin
            cycles($urandom_range(0, 2));
            cap(rnd(), i == n - 1);
        end
    endtask

    task automatic wait_done(input int budget, input int exp_cyc);
        int n;
        n = 0;
        while (!o_drain_done && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_done", 64'(o_drain_done), 64'(1));
        if (exp_cyc > 0) chk("drain_cycles", 64'(n), 64'(exp_cyc));
        chk("beats_outstanding", 64'(exp_q.size()), 64'(0));
        chk("valid_after_done", 64'(o_gpio_valid), 64'(0));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_count"}, 64'(o_entry_count), 64'(0));
        chk({tag, "_valid"}, 64'(o_gpio_valid), 64'(0));
        chk({tag, "_last"}, 64'(o_gpio_last), 64'(0));
        chk({tag, "_data"}, 64'(o_gpio_data), 64'(0));
        chk({tag, "_overflow"}, 64'(o_overflow), 64'(0));
        chk({tag, "_done"}, 64'(o_drain_done), 64'(0));
    endtask

    initial begin
        cycles(3);
        i_rst = 1'b0;
        cycles(1);
        chk_idle("reset");

        // Four runs, ready held high: one beat per cycle.
        run_entries(4);
        wait_done(100, 4 * BEATS + HDR);
        chk("count_after_drain", 64'(o_entry_count), 64'(4));
        cap(rnd(), 1'b0);
        chk("capture_in_done_overflow", 64'(o_overflow), 64'(1));
        chk("capture_in_done_count", 64'(o_entry_count), 64'(4));
        cycles(2);
        clear();
        chk_idle("clear");

        // final_run without a capture must not arm.
        i_final_run = 1'b1;
        cycles(3);
        i_final_run = 1'b0;
        chk("final_no_capture_valid", 64'(o_gpio_valid), 64'(0));
        chk("final_no_capture_done", 64'(o_drain_done), 64'(0));

        rdy_mode = 1;
        run_entries(4);
        wait_done(400, 0);
        clear();

        rdy_mode = 2;
        run_entries(5);
        wait_done(400, 0);
        clear();

        // Seventeen captures into a 16-deep buffer; the overflowing one arms the drain.
        rdy_mode = 0;
        for (int i = 0; i < 16; i++) cap(rnd(), 1'b0);
        chk("full_count", 64'(o_entry_count), 64'(16));
        chk("full_no_overflow_yet", 64'(o_overflow), 64'(0));
        cap(rnd(), 1'b1);
        chk("overflow_count", 64'(o_entry_count), 64'(16));
        chk("overflow_flag", 64'(o_overflow), 64'(1));
        wait_done(400, 16 * BEATS + HDR);
        clear();

        // Clear mid-drain at beat 10, then a fresh capture must land in entry 0.
        run_entries(4);
        repeat (10) @(posedge clk);
        #1;
        clear();
        chk_idle("mid_drain_clear");
        cap(rnd(), 1'b1);
        wait_done(100, BEATS + HDR);

        // Reset coinciding with a capture stores nothing.
        i_capture = 1'b1;
        i_final_run = 1'b1;
        i_spin = rnd();
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        i_capture = 1'b0;
        i_final_run = 1'b0;
        i_rst = 1'b0;
        model_reset();
        cycles(1);
        chk_idle("reset_with_capture");
        cap(rnd(), 1'b1);
        wait_done(100, BEATS + HDR);

        cycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
